// File: rtl/and4ff_rr_sched.sv
// Round-robin scheduler sharing one registered 4-input AND bank between NUM_REQ requesters.
// Optional result self-check (chk_err port) is enabled by defining AND4FF_SCHED_CHECK_EN.
module and4ff_rr_sched #(
  parameter int NO_OF_GATES = 1,
  parameter int NUM_REQ     = 4,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clock0,
  input  logic                           reset0,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*NO_OF_GATES-1:0] req_in0,
  input  logic [NUM_REQ*NO_OF_GATES-1:0] req_in1,
  input  logic [NUM_REQ*NO_OF_GATES-1:0] req_in2,
  input  logic [NUM_REQ*NO_OF_GATES-1:0] req_in3,
  output logic [NO_OF_GATES-1:0]         dp_in0,
  output logic [NO_OF_GATES-1:0]         dp_in1,
  output logic [NO_OF_GATES-1:0]         dp_in2,
  output logic [NO_OF_GATES-1:0]         dp_in3,
  input  logic [NO_OF_GATES-1:0]         dp_result,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [NO_OF_GATES-1:0]         rsp_data
`ifdef AND4FF_SCHED_CHECK_EN
  ,
  output logic                           chk_err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CAPT = 2'd2, RESP = 2'd3} state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [ID_W-1:0]          last_r;
  logic [ID_W-1:0]          id_r;
  logic [ID_W-1:0]          grant_idx_s;
  logic [ID_W-1:0]          cand_s;
  logic                     grant_found_s;
  logic                     accept_s;
  logic [NO_OF_GATES-1:0]   sel0_s;
  logic [NO_OF_GATES-1:0]   sel1_s;
  logic [NO_OF_GATES-1:0]   sel2_s;
  logic [NO_OF_GATES-1:0]   sel3_s;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand_s        = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = ID_W'((int'(last_r) + i) % NUM_REQ);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Operand slices of the currently selected requester
  always_comb begin
    sel0_s = req_in0[int'(grant_idx_s)*NO_OF_GATES +: NO_OF_GATES];
    sel1_s = req_in1[int'(grant_idx_s)*NO_OF_GATES +: NO_OF_GATES];
    sel2_s = req_in2[int'(grant_idx_s)*NO_OF_GATES +: NO_OF_GATES];
    sel3_s = req_in3[int'(grant_idx_s)*NO_OF_GATES +: NO_OF_GATES];
  end

  // Next-state logic and combinational grant; ready is suppressed during reset
  always_comb begin
    state_s   = state_r;
    req_ready = '0;
    accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (grant_found_s && !reset0) begin
          req_ready = NUM_REQ'(1) << grant_idx_s;
          accept_s  = 1'b1;
          state_s   = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: state_s = CAPT;
      CAPT: state_s = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State, arbitration pointer and operand registers
  always_ff @(posedge clock0) begin
    if (reset0) begin
      state_r <= IDLE;
      last_r  <= ID_W'(NUM_REQ - 1);
      id_r    <= '0;
      dp_in0  <= '0;
      dp_in1  <= '0;
      dp_in2  <= '0;
      dp_in3  <= '0;
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        last_r <= grant_idx_s;
        id_r   <= grant_idx_s;
        dp_in0 <= sel0_s;
        dp_in1 <= sel1_s;
        dp_in2 <= sel2_s;
        dp_in3 <= sel3_s;
      end
    end
  end

  // Response channel: capture bank output in CAPT, hold until accepted
  always_ff @(posedge clock0) begin
    if (reset0) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (state_r == CAPT) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_r;
      rsp_data  <= dp_result;
    end else if ((state_r == RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef AND4FF_SCHED_CHECK_EN
  // Sticky flag: bank output disagrees with a local AND of the driven operands
  always_ff @(posedge clock0) begin
    if (reset0) begin
      chk_err <= 1'b0;
    end else if ((state_r == CAPT) && (dp_result != (dp_in0 & dp_in1 & dp_in2 & dp_in3))) begin
      chk_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_and4ff_rr_sched.sv
// Directed self-checking bench for and4ff_rr_sched with a registered 4-input AND bank model.
// Define AND4FF_SCHED_CHECK_EN to also exercise the chk_err path.
module tb_and4ff_rr_sched;
  localparam int G = 4;
  localparam int N = 4;

  logic           clock0 = 1'b0;
  logic           reset0;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*G-1:0] req_in0, req_in1, req_in2, req_in3;
  logic [G-1:0]   dp_in0, dp_in1, dp_in2, dp_in3;
  logic [G-1:0]   dp_result = '0;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [G-1:0]   rsp_data;
  logic           corrupt = 1'b0;
`ifdef AND4FF_SCHED_CHECK_EN
  logic           chk_err;
`endif

  int total = 0;
  int bad   = 0;

  and4ff_rr_sched #(.NO_OF_GATES(G), .NUM_REQ(N)) dut (
    .clock0(clock0), .reset0(reset0),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3),
    .dp_in0(dp_in0), .dp_in1(dp_in1), .dp_in2(dp_in2), .dp_in3(dp_in3),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef AND4FF_SCHED_CHECK_EN
    , .chk_err(chk_err)
`endif
  );

  always #5 clock0 = ~clock0;

  // bank model: registered AND, optionally forced to zero
  always_ff @(posedge clock0) begin
    dp_result <= corrupt ? '0 : (dp_in0 & dp_in1 & dp_in2 & dp_in3);
  end

  task automatic tick;
    @(posedge clock0);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    reset0 = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    reset0 = 1'b0;
  endtask

  task automatic test_reset;
    reset0 = 1'b1;
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    req_in0 = 16'hFFFF; req_in1 = 16'hFFFF; req_in2 = 16'hFFFF; req_in3 = 16'hFFFF;
    tick();
    tick();
    settle();
    total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    total++; if (rsp_data !== 4'h0) begin bad++; $display("FAIL reset_rsp_data got=%h exp=0", rsp_data); end
    total++;
    if ({dp_in0, dp_in1, dp_in2, dp_in3} !== 16'h0000) begin
      bad++; $display("FAIL reset_dp_in got=%h exp=0000", {dp_in0, dp_in1, dp_in2, dp_in3});
    end
    req_valid = '0;
    reset0 = 1'b0;
  endtask

  task automatic test_single;
    // requester 2: F & F & E & B = A; other slices carry unrelated values
    req_in0 = 16'h3F21; req_in1 = 16'h5F47; req_in2 = 16'h6E98; req_in3 = 16'h7BCD;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (c == 1) req_valid = '0;
      settle();
      total++;
      if (req_ready !== ((c == 0) ? 4'b0100 : 4'b0000)) begin
        bad++; $display("FAIL single_ready c=%0d got=%b", c, req_ready);
      end
      total++;
      if (rsp_valid !== (c == 3)) begin
        bad++; $display("FAIL single_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, (c == 3));
      end
      if (c == 1) begin
        total++;
        if ({dp_in0, dp_in1, dp_in2, dp_in3} !== 16'hFFEB) begin
          bad++; $display("FAIL single_dp_in got=%h exp=FFEB", {dp_in0, dp_in1, dp_in2, dp_in3});
        end
      end
      if (c == 3) begin
        total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL single_rsp_id got=%0d exp=2", rsp_id); end
        total++; if (rsp_data !== 4'hA) begin bad++; $display("FAIL single_rsp_data got=%h exp=A", rsp_data); end
      end
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_rdy;
    logic [1:0] exp_id;
    logic [3:0] exp_data;
    req_in0 = 16'hFFFF; req_in1 = 16'hFFFF; req_in2 = 16'hFFFF; req_in3 = 16'h4321;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    reset0 = 1'b1;
    tick();
    tick();
    reset0 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c > 0) tick();
      settle();
      exp_id = 2'((c / 4) % 4);
      exp_rdy = ((c % 4) == 0) ? (4'b0001 << exp_id) : 4'b0000;
      exp_data = 4'(exp_id) + 4'd1;
      total++;
      if (req_ready !== exp_rdy) begin
        bad++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy);
      end
      if ((c % 4) == 3) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== exp_data) begin
          bad++; $display("FAIL rr_rsp c=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                          c, rsp_valid, rsp_id, rsp_data, exp_id, exp_data);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_back_pressure;
    // requester 1: 6 & 7 & E & F = 6
    req_in0 = 16'h0060; req_in1 = 16'h0070; req_in2 = 16'h00E0; req_in3 = 16'h00F0;
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      if (c == 1) req_valid = '0;
      if (c == 4) req_valid = 4'hF;
      if (c == 8) begin req_valid = '0; rsp_ready = 1'b1; end
      settle();
      total++;
      if (req_ready !== ((c == 0) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL bp_ready c=%0d got=%b", c, req_ready);
      end
      total++;
      if (rsp_valid !== (c >= 3 && c <= 8)) begin
        bad++; $display("FAIL bp_rsp_valid c=%0d got=%b", c, rsp_valid);
      end
      if (c >= 3 && c <= 8) begin
        total++;
        if (rsp_id !== 2'd1 || rsp_data !== 4'h6) begin
          bad++; $display("FAIL bp_hold c=%0d got id=%0d d=%h exp id=1 d=6", c, rsp_id, rsp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      case (c)
        1: req_valid = '0;
        2: begin reset0 = 1'b1; req_valid = 4'b1010; end
        3: reset0 = 1'b0;
        4: req_valid = '0;
        default: ;
      endcase
      settle();
      total++;
      if (req_ready !== ((c == 0 || c == 3) ? 4'b0010 : 4'b0000)) begin
        bad++; $display("FAIL mid_ready c=%0d got=%b", c, req_ready);
      end
      total++;
      if (rsp_valid !== (c == 6)) begin
        bad++; $display("FAIL mid_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, (c == 6));
      end
      if (c == 6) begin
        total++;
        if (rsp_id !== 2'd1 || rsp_data !== 4'h6) begin
          bad++; $display("FAIL mid_rsp got id=%0d d=%h exp id=1 d=6", rsp_id, rsp_data);
        end
      end
    end
  endtask

`ifdef AND4FF_SCHED_CHECK_EN
  task automatic test_check;
    do_reset();
    req_in0 = 16'h0F00; req_in1 = 16'h0F00; req_in2 = 16'h0E00; req_in3 = 16'h0B00;
    corrupt = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) tick();
      case (c)
        1: req_valid = '0;
        3: begin corrupt = 1'b0; req_valid = 4'b0100; end
        5: req_valid = '0;
        8: reset0 = 1'b1;
        9: reset0 = 1'b0;
        default: ;
      endcase
      settle();
      if (c == 2 || c == 9) begin
        total++; if (chk_err !== 1'b0) begin bad++; $display("FAIL chk_clear c=%0d got=%b exp=0", c, chk_err); end
      end
      if (c >= 3 && c <= 8) begin
        total++; if (chk_err !== 1'b1) begin bad++; $display("FAIL chk_sticky c=%0d got=%b exp=1", c, chk_err); end
      end
      if (c == 3) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'h0) begin
          bad++; $display("FAIL chk_bad_rsp got v=%b d=%h exp v=1 d=0", rsp_valid, rsp_data);
        end
      end
      if (c == 7) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_data !== 4'hA) begin
          bad++; $display("FAIL chk_good_rsp got v=%b d=%h exp v=1 d=A", rsp_valid, rsp_data);
        end
      end
    end
  endtask
`endif

  initial begin
    reset0 = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_in0 = '0; req_in1 = '0; req_in2 = '0; req_in3 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
`ifdef AND4FF_SCHED_CHECK_EN
    test_check();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/and4ff_rr_sched.md
Name: and4ff_rr_sched

Overview:
- Round-robin scheduler that shares one registered 4-input AND bank (NO_OF_GATES lanes, 1-cycle registered output) between NUM_REQ requesters.
- Accepts one operand set at a time via valid/ready and drives it into the bank.
- Waits out the bank's register latency, then returns the result with the requester's ID on a valid/ready response channel.
- Sits between the requester fabric and the bank instance; the bank runs on the same clock0.

Parameters:
- NO_OF_GATES, 1, lanes per operand/result word; must match the bank.
- NUM_REQ, 4, number of requesters, 1..16.
- ID_W (localparam), NUM_REQ>1 ? $clog2(NUM_REQ) : 1, width of rsp_id.

Ports:
- clock0  in  1  sole clock, rising edge
- reset0  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero
- req_in0  in  NUM_REQ*NO_OF_GATES  operand 0; requester k uses slice [k*NO_OF_GATES +: NO_OF_GATES] (same packing for req_in1..3)
- req_in1  in  NUM_REQ*NO_OF_GATES  operand 1
- req_in2  in  NUM_REQ*NO_OF_GATES  operand 2
- req_in3  in  NUM_REQ*NO_OF_GATES  operand 3
- dp_in0..dp_in3  out  NO_OF_GATES each  operands to bank; registered
- dp_result  in  NO_OF_GATES  bank registered output
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  index of the requester the response belongs to
- rsp_data  out  NO_OF_GATES  captured AND result

Behaviour:
- Reset values (reset0 high at a rising edge):
  - state=IDLE; rsp_valid=0; rsp_id=0; rsp_data=0; dp_in0..3=0.
  - Round-robin pointer last=NUM_REQ-1, so index 0 has top priority.
  - req_ready forced 0 while reset0 is high.
- FSM states: IDLE, LOAD, CAPT, RESP.
- IDLE:
  - Choose the first k with req_valid[k]=1, searching last+1, last+2, … modulo NUM_REQ.
  - req_ready[k]=1, combinational and only in IDLE.
  - On that edge: latch k's four slices into dp_in0..3, latch k into an ID register, set last=k, go to LOAD.
  - No valid request: stay in IDLE, req_ready=0.
- LOAD: dp_in held stable; the bank samples at the end of this cycle; go to CAPT.
- CAPT: dp_result is valid; capture it into rsp_data, ID into rsp_id, set rsp_valid=1; go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid&&rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE.
  - dp_in stays at the last operands (no spurious change).
- Latency and throughput:
  - Acceptance edge to rsp_valid high = 2 edges, i.e. rsp_valid is first seen in the 3rd cycle after req_ready.
  - At most one operation in flight; minimum 4 cycles per operation with rsp_ready tied high.
- Fairness: a continuously asserting requester is granted at most once per NUM_REQ grants while others wait.
- req_valid deasserted before grant: no effect. Operand values outside the accepted cycle are ignored.
- Reset mid-operation (any state): operation dropped, no response produced, pointer reset to NUM_REQ-1.
- NUM_REQ=1: pointer logic degenerates; rsp_id is always 0.

Optional Feature:
- Macro AND4FF_SCHED_CHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit).
  - In CAPT, compare dp_result with dp_in0&dp_in1&dp_in2&dp_in3 computed locally.
  - On mismatch, chk_err is set to 1 and stays set (sticky) until reset0.
  - The response is still delivered unchanged.
- Undefined: no chk_err port and no compare logic; behaviour otherwise identical.

Test Plan (NO_OF_GATES=4, NUM_REQ=4, bank = registered 4-input AND):
- Hold reset0=1 for 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, dp_in0..3=0.
- Requester 2 only: in0=F, in1=F, in2=E, in3=B, rsp_ready=1 -> req_ready=4'b0100 for one cycle; rsp_valid in the 3rd cycle after, with rsp_id=2, rsp_data=4'hA, for exactly one cycle.
- All four req_valid held high and rsp_ready=1 from reset -> grant order 0,1,2,3,0,1; a new req_ready pulse every 4 cycles.
- rsp_ready=0 for 5 cycles while rsp_valid=1 -> rsp_valid, rsp_id and rsp_data constant; req_ready=0; completes on the first cycle rsp_ready=1.
- reset0 pulsed 1 cycle while in CAPT for requester 1 -> no response for requester 1; with 1 and 3 requesting afterwards, requester 1 is granted first.
- With AND4FF_SCHED_CHECK_EN: bank model forced to return 4'h0 for expected 4'hA -> chk_err=1 after CAPT and stays 1 across later correct operations until reset0.
